operand_stack: RTL
==================

OPERAND_STACK -- requirements
Module: operand_stack

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of entries; power of two, >=4.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port push  input  1  push din onto stack.
REQ-006 Port pop  input  1  remove top entry, return it on dout.
REQ-007 Port tos  input  1  read top entry to dout without removal.
REQ-008 Port dup  input  1  push a copy of top entry.
REQ-009 Port swap  input  1  exchange top and second entries.
REQ-010 Port err_clr  input  1  clear sticky error flags.
REQ-011 Port din  input  WIDTH  push / replace data.
REQ-012 Port dout  output  WIDTH  registered read data.
REQ-013 Port dout_valid  output  1  one-cycle pulse: dout updated by the previous op.
REQ-014 Port count  output  $clog2(DEPTH)+1  current number of entries, registered.
REQ-015 Port stack_empty  output  1  count==0, decoded from count register.
REQ-016 Port stack_full  output  1  count==DEPTH, decoded from count register.
REQ-017 Port overflow  output  1  sticky: a push or dup was refused because the stack was full.
REQ-018 Port underflow  output  1  sticky: an op was refused because the stack held too few entries.

Function
REQ-019 Storage: DEPTH x WIDTH register array; top = entry[count-1], second = entry[count-2].
REQ-020 Op priority per cycle: {push,pop} > dup > swap > tos; lower-priority strobes in the same cycle are ignored with no effect.
REQ-021 push alone, not full: entry[count]<=din, count+1; full: no state change, overflow<=1.
REQ-022 pop alone, not empty: dout<=top, count-1, dout_valid=1 next cycle; empty: dout unchanged, underflow<=1.
REQ-023 push and pop together (replace), not empty: dout<=top, entry[count-1]<=din, count unchanged, dout_valid pulse; empty: no change, underflow<=1.
REQ-024 Replace on a full stack is legal and does not set overflow.
REQ-025 tos, not empty: dout<=top, dout_valid pulse, count unchanged; empty: underflow<=1.
REQ-026 dup, 1<=count<DEPTH: entry[count]<=top, count+1; empty: underflow<=1; full: overflow<=1; empty takes precedence over full.
REQ-027 swap, count>=2: top and second exchanged in one cycle; count<2: no change, underflow<=1.
REQ-028 All ops complete in one cycle; back-to-back ops on consecutive cycles are legal and each sees the state left by the previous one.
REQ-029 dout holds its value until the next successful pop/tos/replace; dout_valid is low in all other cycles.
REQ-030 err_clr clears overflow and underflow; when an error occurs in the same cycle as err_clr, the flag is set (set wins).
REQ-031 Refused ops never modify storage, count or dout.
REQ-032 count never wraps: it saturates at 0 and at DEPTH per REQ-021..027.

Reset
REQ-033 rst high at an edge: count=0, dout=0, dout_valid=0, overflow=0, underflow=0; stack_empty=1 and stack_full=0 follow.
REQ-034 rst overrides every strobe in the same cycle; storage contents are not reset and are not observable after reset.
REQ-035 Deasserting rst mid-sequence returns the block to an empty stack; no op from the reset cycle takes effect.

Verification (WIDTH=8, DEPTH=4)
REQ-036 push 0x11,0x22,0x33,0x44 -> count=4, stack_full=1; 5th push 0x55 -> count=4, overflow=1; pop -> dout=0x44, dout_valid pulse.
REQ-037 From reset, pop -> underflow=1, dout=0x00, count=0; same cycle err_clr with a further pop -> underflow stays 1; next err_clr alone -> 0.
REQ-038 Stack 0x0A,0x0B; push+pop with din=0xC0 -> dout=0x0B, count=2; then tos -> dout=0xC0.
REQ-039 Stack 0x01,0x02; swap then pop,pop -> dout 0x01 then 0x02; swap with count=1 -> underflow=1, contents unchanged.
REQ-040 Stack 0x7F; dup with tos asserted in the same cycle -> count=2, no dout_valid; then pop twice -> 0x7F, 0x7F, stack_empty=1.
REQ-041 Stack of 3 entries; rst asserted together with push -> count=0, stack_empty=1, all flags 0, dout=0x00.

Source files
------------

// File: rtl/operand_stack.sv
// rtl/operand_stack.sv - register-file operand stack with push/pop/replace/dup/swap/tos and sticky errors
// One operation per cycle, chosen by fixed priority; refused ops only raise a sticky flag.
module operand_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       tos,
  input  logic                       dup,
  input  logic                       swap,
  input  logic                       err_clr,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       stack_empty,
  output logic                       stack_full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] LP_ONE   = CW'(1);
  localparam logic [CW-1:0] LP_TWO   = CW'(2);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic             w_ge2;
  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_sec_idx;
  logic [AW-1:0]    w_cnt_idx;
  logic [WIDTH-1:0] w_top;
  logic [WIDTH-1:0] w_sec;

  logic             w_we0;
  logic [AW-1:0]    w_wa0;
  logic [WIDTH-1:0] w_wd0;
  logic             w_we1;
  logic [AW-1:0]    w_wa1;
  logic [WIDTH-1:0] w_wd1;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_dout_nxt;
  logic             w_dv_nxt;
  logic             w_ovf_set;
  logic             w_udf_set;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == LP_DEPTH);
  assign w_ge2     = (r_count >= LP_TWO);
  // Indices wrap harmlessly when count is too small; those reads are never used.
  assign w_top_idx = AW'(r_count - LP_ONE);
  assign w_sec_idx = AW'(r_count - LP_TWO);
  assign w_cnt_idx = AW'(r_count);
  assign w_top     = r_mem[w_top_idx];
  assign w_sec     = r_mem[w_sec_idx];

  always_comb begin
    w_we0      = 1'b0;
    w_wa0      = w_top_idx;
    w_wd0      = din;
    w_we1      = 1'b0;
    w_wa1      = w_sec_idx;
    w_wd1      = w_top;
    w_cnt_nxt  = r_count;
    w_dout_nxt = r_dout;
    w_dv_nxt   = 1'b0;
    w_ovf_set  = 1'b0;
    w_udf_set  = 1'b0;

    if (push && pop) begin
      // Replace: legal on a full stack, so only emptiness can refuse it.
      if (w_empty) begin
        w_udf_set = 1'b1;
      end else begin
        w_dout_nxt = w_top;
        w_dv_nxt   = 1'b1;
        w_we0      = 1'b1;
        w_wa0      = w_top_idx;
        w_wd0      = din;
      end
    end else if (push) begin
      if (w_full) begin
        w_ovf_set = 1'b1;
      end else begin
        w_we0     = 1'b1;
        w_wa0     = w_cnt_idx;
        w_wd0     = din;
        w_cnt_nxt = r_count + LP_ONE;
      end
    end else if (pop) begin
      if (w_empty) begin
        w_udf_set = 1'b1;
      end else begin
        w_dout_nxt = w_top;
        w_dv_nxt   = 1'b1;
        w_cnt_nxt  = r_count - LP_ONE;
      end
    end else if (dup) begin
      if (w_empty) begin
        w_udf_set = 1'b1;
      end else if (w_full) begin
        w_ovf_set = 1'b1;
      end else begin
        w_we0     = 1'b1;
        w_wa0     = w_cnt_idx;
        w_wd0     = w_top;
        w_cnt_nxt = r_count + LP_ONE;
      end
    end else if (swap) begin
      if (!w_ge2) begin
        w_udf_set = 1'b1;
      end else begin
        w_we0 = 1'b1;
        w_wa0 = w_top_idx;
        w_wd0 = w_sec;
        w_we1 = 1'b1;
        w_wa1 = w_sec_idx;
        w_wd1 = w_top;
      end
    end else if (tos) begin
      if (w_empty) begin
        w_udf_set = 1'b1;
      end else begin
        w_dout_nxt = w_top;
        w_dv_nxt   = 1'b1;
      end
    end
  end

  // Storage is deliberately not reset; an empty count hides stale entries.
  always_ff @(posedge clk) begin
    if (!rst && w_we0) r_mem[w_wa0] <= w_wd0;
    if (!rst && w_we1) r_mem[w_wa1] <= w_wd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_count      <= w_cnt_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_dv_nxt;
      r_overflow   <= (r_overflow  & ~err_clr) | w_ovf_set;
      r_underflow  <= (r_underflow & ~err_clr) | w_udf_set;
    end
  end

  assign dout        = r_dout;
  assign dout_valid  = r_dout_valid;
  assign count       = r_count;
  assign stack_empty = (r_count == '0);
  assign stack_full  = (r_count == LP_DEPTH);
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule
